// File: rtl/dcache_pkg.sv
// Shared types, default geometry and helpers for the direct-mapped data cache.
package dcache_pkg;

    localparam int WORD_W         = 32;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_NUM_SETS   = 16;
    localparam int DEF_OFF_W      = $clog2(DEF_LINE_WORDS);
    localparam int DEF_IDX_W      = $clog2(DEF_NUM_SETS);
    localparam int DEF_TAG_W      = WORD_W - DEF_IDX_W - DEF_OFF_W - 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WB_REQ    = 3'd1,
        WB_WAIT   = 3'd2,
        FILL_REQ  = 3'd3,
        FILL_WAIT = 3'd4
    } state_e;

    // Rebuilds a line-aligned byte address from its tag and index fields.
    function automatic logic [31:0] line_addr(input logic [31:0] tag_v,
                                              input logic [31:0] index_v,
                                              input int          idx_w,
                                              input int          off_w);
        return (tag_v << (idx_w + off_w + 32'sd2)) | (index_v << (off_w + 32'sd2));
    endfunction

    // Performance counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/dirty/tag/data storage for the cache: asynchronous read, one
// synchronous write per cycle (line fill, word store, or dirty clear).
module dcache_array
    import dcache_pkg::*;
#(
    parameter int OFF_W = DEF_OFF_W,
    parameter int IDX_W = DEF_IDX_W,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [IDX_W-1:0]                  index,
    output logic                              rd_valid,
    output logic                              rd_dirty,
    output logic [TAG_W-1:0]                  rd_tag,
    output logic [WORD_W*(2**OFF_W)-1:0]      rd_line,
    input  logic                              line_we,
    input  logic [TAG_W-1:0]                  line_tag,
    input  logic [WORD_W*(2**OFF_W)-1:0]      line_data,
    input  logic                              word_we,
    input  logic [OFF_W-1:0]                  word_off,
    input  logic [WORD_W-1:0]                 word_data,
    input  logic                              clean_we
);

    localparam int NUM_SETS = 2 ** IDX_W;
    localparam int LINE_W   = WORD_W * (2 ** OFF_W);

    logic [NUM_SETS-1:0] valid_q, valid_d;
    logic [NUM_SETS-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [TAG_W-1:0]    tag_d  [NUM_SETS];
    logic [LINE_W-1:0]   data_q [NUM_SETS];
    logic [LINE_W-1:0]   data_d [NUM_SETS];

    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];
    assign rd_tag   = tag_q[index];
    assign rd_line  = data_q[index];

    // Next-state of the addressed set; a line fill has priority over a word store.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (line_we) begin
            valid_d[index] = 1'b1;
            dirty_d[index] = 1'b0;
            tag_d[index]   = line_tag;
            data_d[index]  = line_data;
        end else if (word_we) begin
            data_d[index][{word_off, 5'd0} +: WORD_W] = word_data;
            dirty_d[index] = 1'b1;
        end else if (clean_we) begin
            dirty_d[index] = 1'b0;
        end else begin
            dirty_d = dirty_q;
        end
    end

    // Flag storage: reset invalidates and cleans every set at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data storage carry no reset; they are meaningless while invalid.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller: zero-latency
// hit path, miss FSM towards line-granular memory, saturating hit/miss counters.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int NUM_SETS   = DEF_NUM_SETS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         is_input_valid,
    input  logic [31:0]                  addr,
    input  logic                         mem_read,
    input  logic                         mem_write,
    input  logic [31:0]                  din,
    output logic                         is_ready,
    output logic                         is_output_valid,
    output logic                         is_hit,
    output logic [31:0]                  dout,
    output logic                         dm_req_valid,
    output logic                         dm_req_write,
    output logic [31:0]                  dm_req_addr,
    output logic [32*LINE_WORDS-1:0]     dm_req_data,
    input  logic                         dm_ready,
    input  logic                         dm_resp_valid,
    input  logic [32*LINE_WORDS-1:0]     dm_resp_data,
    output logic [31:0]                  hit_count,
    output logic [31:0]                  miss_count
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = WORD_W - IDX_W - OFF_W - 2;
    localparam int LINE_W = WORD_W * LINE_WORDS;

    state_e              state_q, state_d;
    logic [31:0]         hit_count_q, hit_count_d;
    logic [31:0]         miss_count_q, miss_count_d;
    logic                dm_req_valid_q, dm_req_valid_d;
    logic                dm_req_write_q, dm_req_write_d;
    logic [31:0]         dm_req_addr_q, dm_req_addr_d;
    logic [LINE_W-1:0]   dm_req_data_q, dm_req_data_d;

    logic [OFF_W-1:0]    offset_s;
    logic [IDX_W-1:0]    index_s;
    logic [TAG_W-1:0]    tag_s;
    logic                rd_valid_s, rd_dirty_s;
    logic [TAG_W-1:0]    rd_tag_s;
    logic [LINE_W-1:0]   rd_line_s;
    logic                lookup_hit_s, is_idle_s, is_hit_s;
    logic [31:0]         dout_s;
    logic                line_we_s, word_we_s, clean_we_s;
    logic                unused_s;

    assign offset_s = addr[OFF_W+1:2];
    assign index_s  = addr[IDX_W+OFF_W+1:OFF_W+2];
    assign tag_s    = addr[31:IDX_W+OFF_W+2];
    // Loads are simply "not a store", and byte lanes are never addressed.
    assign unused_s = ^{addr[1:0], mem_read};

    dcache_array #(
        .OFF_W (OFF_W),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .index     (index_s),
        .rd_valid  (rd_valid_s),
        .rd_dirty  (rd_dirty_s),
        .rd_tag    (rd_tag_s),
        .rd_line   (rd_line_s),
        .line_we   (line_we_s),
        .line_tag  (tag_s),
        .line_data (dm_resp_data),
        .word_we   (word_we_s),
        .word_off  (offset_s),
        .word_data (din),
        .clean_we  (clean_we_s)
    );

    assign lookup_hit_s = rd_valid_s && (rd_tag_s == tag_s);

    // Combinational hit path: the pipeline advances on the same edge as the lookup.
    always_comb begin
        is_idle_s = (state_q == IDLE);
        is_hit_s  = 1'b0;
        dout_s    = 32'd0;
        if (is_idle_s && is_input_valid && lookup_hit_s) begin
            is_hit_s = 1'b1;
            dout_s   = rd_line_s[{offset_s, 5'd0} +: WORD_W];
        end else begin
            is_hit_s = 1'b0;
            dout_s   = 32'd0;
        end
    end

    assign is_ready        = is_idle_s;
    assign is_output_valid = is_idle_s && is_input_valid;
    assign is_hit          = is_hit_s;
    assign dout            = dout_s;

    // Miss FSM, counters and registered memory-request fields.
    always_comb begin
        state_d        = state_q;
        hit_count_d    = hit_count_q;
        miss_count_d   = miss_count_q;
        dm_req_valid_d = 1'b0;
        dm_req_write_d = dm_req_write_q;
        dm_req_addr_d  = dm_req_addr_q;
        dm_req_data_d  = dm_req_data_q;
        line_we_s      = 1'b0;
        word_we_s      = 1'b0;
        clean_we_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_input_valid && is_hit_s) begin
                    hit_count_d = sat_inc(hit_count_q);
                    word_we_s   = mem_write;
                end else if (is_input_valid) begin
                    miss_count_d = sat_inc(miss_count_q);
                    state_d      = (rd_valid_s && rd_dirty_s) ? WB_REQ : FILL_REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            WB_REQ: begin
                if (dm_ready) begin
                    dm_req_valid_d = 1'b1;
                    dm_req_write_d = 1'b1;
                    dm_req_addr_d  = line_addr(32'(rd_tag_s), 32'(index_s), IDX_W, OFF_W);
                    dm_req_data_d  = rd_line_s;
                    state_d        = WB_WAIT;
                end else begin
                    state_d = WB_REQ;
                end
            end
            WB_WAIT: begin
                if (dm_resp_valid) begin
                    clean_we_s = 1'b1;
                    state_d    = FILL_REQ;
                end else begin
                    state_d = WB_WAIT;
                end
            end
            FILL_REQ: begin
                if (dm_ready) begin
                    dm_req_valid_d = 1'b1;
                    dm_req_write_d = 1'b0;
                    dm_req_addr_d  = line_addr(32'(tag_s), 32'(index_s), IDX_W, OFF_W);
                    state_d        = FILL_WAIT;
                end else begin
                    state_d = FILL_REQ;
                end
            end
            FILL_WAIT: begin
                if (dm_resp_valid) begin
                    line_we_s = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = FILL_WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller state; reset abandons any outstanding memory transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            hit_count_q    <= 32'd0;
            miss_count_q   <= 32'd0;
            dm_req_valid_q <= 1'b0;
            dm_req_write_q <= 1'b0;
            dm_req_addr_q  <= 32'd0;
            dm_req_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            hit_count_q    <= hit_count_d;
            miss_count_q   <= miss_count_d;
            dm_req_valid_q <= dm_req_valid_d;
            dm_req_write_q <= dm_req_write_d;
            dm_req_addr_q  <= dm_req_addr_d;
            dm_req_data_q  <= dm_req_data_d;
        end
    end

    assign dm_req_valid = dm_req_valid_q;
    assign dm_req_write = dm_req_write_q;
    assign dm_req_addr  = dm_req_addr_q;
    assign dm_req_data  = dm_req_data_q;
    assign hit_count    = hit_count_q;
    assign miss_count   = miss_count_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural cache model.
module tb_dcache_ctrl;

    logic         clk;
    logic         reset;
    logic         is_input_valid;
    logic [31:0]  addr;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  din;
    logic         is_ready;
    logic         is_output_valid;
    logic         is_hit;
    logic [31:0]  dout;
    logic         dm_req_valid;
    logic         dm_req_write;
    logic [31:0]  dm_req_addr;
    logic [127:0] dm_req_data;
    logic         dm_ready;
    logic         dm_resp_valid;
    logic [127:0] dm_resp_data;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    dcache_ctrl #(.LINE_WORDS(4), .NUM_SETS(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .is_input_valid  (is_input_valid),
        .addr            (addr),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .din             (din),
        .is_ready        (is_ready),
        .is_output_valid (is_output_valid),
        .is_hit          (is_hit),
        .dout            (dout),
        .dm_req_valid    (dm_req_valid),
        .dm_req_write    (dm_req_write),
        .dm_req_addr     (dm_req_addr),
        .dm_req_data     (dm_req_data),
        .dm_ready        (dm_ready),
        .dm_resp_valid   (dm_resp_valid),
        .dm_resp_data    (dm_resp_data),
        .hit_count       (hit_count),
        .miss_count      (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         wr;
        logic [31:0]  a;
        logic [127:0] d;
    } req_t;

    typedef struct {
        logic [31:0]  a;
        logic         wr;
        logic [31:0]  wd;
        logic         exp_hit;
        logic [31:0]  exp_dout;
        int           exp_cyc;
        int           exp_nreq;
        logic [127:0] exp_wb_data;
    } vec_t;

    int           n_chk = 0;
    int           n_err = 0;
    int           resp_lat;
    logic         rand_ready;
    req_t         req_log[$];
    logic [127:0] mem[logic [31:0]];
    logic [127:0] ref_mem[logic [31:0]];
    vec_t         vecs[7];

    // Reference cache state for the randomized phase.
    logic         rv[16];
    logic         rdty[16];
    logic [23:0]  rt[16];
    logic [127:0] rdat[16];
    int           mh, mm;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] dflt_line(input logic [31:0] la);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) l[i*32 +: 32] = (la + 32'(i * 4)) ^ 32'h5A00_0000;
        return l;
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] la);
        if (mem.exists(la)) return mem[la];
        return dflt_line(la);
    endfunction

    function automatic logic [127:0] ref_line(input logic [31:0] la);
        if (ref_mem.exists(la)) return ref_mem[la];
        return dflt_line(la);
    endfunction

    // Line-granular memory: logs each request and answers after a latency.
    initial begin : responder
        int           pend_cnt;
        logic [127:0] pend_data;
        pend_cnt  = 0;
        pend_data = '0;
        forever begin
            @(negedge clk);
            dm_resp_valid = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    dm_resp_valid = 1'b1;
                    dm_resp_data  = pend_data;
                end
            end
            if (dm_req_valid === 1'b1) begin
                req_log.push_back('{dm_req_write, dm_req_addr, dm_req_data});
                if (dm_req_write) begin
                    mem[dm_req_addr] = dm_req_data;
                    pend_data = '0;
                end else begin
                    pend_data = mem_line(dm_req_addr);
                end
                pend_cnt = (resp_lat == 0) ? int'($urandom_range(1, 4)) : resp_lat;
            end
        end
    end

    // Presents one request from just after a falling edge until it completes.
    task automatic access(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                          output logic first_hit, output logic [31:0] rd, output int cyc);
        addr = a; mem_read = ~wr; mem_write = wr; din = wd; is_input_valid = 1'b1;
        #1;
        first_hit = is_hit;
        cyc = 0;
        while (!(is_ready && is_output_valid && is_hit) && cyc < 200) begin
            @(negedge clk);
            if (rand_ready) dm_ready = ($urandom_range(0, 3) != 0);
            #1;
            cyc++;
        end
        if (cyc >= 200) chk($sformatf("access_timeout_%0h", a), 1'b0, 1'b1);
        rd = dout;
        @(negedge clk);
        is_input_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, expected below 500000", $time);
        $fatal(1);
    end

    initial begin
        logic        fh;
        logic [31:0] rd;
        int          cyc;
        int          k;
        logic [31:0] a;
        logic        wr;
        logic [31:0] wd;
        logic [3:0]  s;
        logic [23:0] t;
        int          wi;
        logic        eh;
        logic [31:0] erd;
        logic [31:0] la;
        req_t        exp_q[$];

        reset = 1'b1; is_input_valid = 1'b0; addr = 32'd0; mem_read = 1'b0;
        mem_write = 1'b0; din = 32'd0; dm_ready = 1'b1; dm_resp_valid = 1'b0;
        dm_resp_data = '0; rand_ready = 1'b0; resp_lat = 3;
        mem[32'h100] = 128'h00000004_00000003_00000002_00000001;

        vecs[0] = '{32'h100, 1'b0, 32'h0,    1'b0, 32'h1,        6,  1, 128'h0};
        vecs[1] = '{32'h104, 1'b1, 32'hDEAD, 1'b1, 32'h0,        0,  0, 128'h0};
        vecs[2] = '{32'h104, 1'b0, 32'h0,    1'b1, 32'hDEAD,     0,  0, 128'h0};
        vecs[3] = '{32'h500, 1'b0, 32'h0,    1'b0, 32'h5A000500, 11, 2,
                    128'h00000004_00000003_0000DEAD_00000001};
        vecs[4] = '{32'h100, 1'b0, 32'h0,    1'b0, 32'h1,        6,  1, 128'h0};
        vecs[5] = '{32'h104, 1'b0, 32'h0,    1'b1, 32'hDEAD,     0,  0, 128'h0};
        vecs[6] = '{32'h10C, 1'b0, 32'h0,    1'b1, 32'h4,        0,  0, 128'h0};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_is_ready", is_ready, 1'b1);
        chk("rst_out_valid", is_output_valid, 1'b0);
        chk("rst_is_hit", is_hit, 1'b0);
        chk("rst_dout", dout, 32'h0);
        chk("rst_req_valid", dm_req_valid, 1'b0);
        chk("rst_req_write", dm_req_write, 1'b0);
        chk("rst_req_addr", dm_req_addr, 32'h0);
        chk("rst_req_data", dm_req_data, 128'h0);
        chk("rst_hit_count", hit_count, 32'h0);
        chk("rst_miss_count", miss_count, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            req_log.delete();
            access(vecs[i].a, vecs[i].wr, vecs[i].wd, fh, rd, cyc);
            chk($sformatf("vec%0d_first_hit", i), fh, vecs[i].exp_hit);
            if (!vecs[i].wr) chk($sformatf("vec%0d_dout", i), rd, vecs[i].exp_dout);
            chk($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp_cyc);
            chk($sformatf("vec%0d_nreq", i), req_log.size(), vecs[i].exp_nreq);
            if (vecs[i].exp_nreq > 0 && req_log.size() > 0) begin
                chk($sformatf("vec%0d_fill_write", i), req_log[req_log.size()-1].wr, 1'b0);
                chk($sformatf("vec%0d_fill_addr", i), req_log[req_log.size()-1].a,
                    vecs[i].a & 32'hFFFF_FFF0);
            end
            if (vecs[i].exp_nreq == 2 && req_log.size() == 2) begin
                chk($sformatf("vec%0d_wb_write", i), req_log[0].wr, 1'b1);
                chk($sformatf("vec%0d_wb_addr", i), req_log[0].a, 32'h100);
                chk($sformatf("vec%0d_wb_data", i), req_log[0].d, vecs[i].exp_wb_data);
            end
        end
        chk("tbl_hit_count", hit_count, 32'd7);
        chk("tbl_miss_count", miss_count, 32'd3);

        // No request presented: nothing reported even though 0x104 is resident.
        addr = 32'h104; mem_read = 1'b1; #1;
        chk("idle_no_req_hit", is_hit, 1'b0);
        chk("idle_no_req_ovalid", is_output_valid, 1'b0);
        mem_read = 1'b0;
        @(negedge clk);

        // Memory not ready while FILL_REQ is pending.
        req_log.delete();
        dm_ready = 1'b0;
        addr = 32'h2040; mem_read = 1'b1; is_input_valid = 1'b1; #1;
        chk("stall_first_hit", is_hit, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk($sformatf("stall%0d_is_ready", i), is_ready, 1'b0);
            chk($sformatf("stall%0d_req_valid", i), dm_req_valid, 1'b0);
        end
        dm_ready = 1'b1;
        k = 0;
        while (!(is_ready && is_hit) && k < 50) begin @(negedge clk); #1; k++; end
        chk("stall_completed", k < 50, 1'b1);
        chk("stall_dout", dout, 32'h5A002040);
        chk("stall_nreq", req_log.size(), 1);
        @(negedge clk);
        is_input_valid = 1'b0; mem_read = 1'b0;

        // Reset during FILL_WAIT; the late response must be ignored.
        resp_lat = 6;
        addr = 32'h3080; mem_read = 1'b1; is_input_valid = 1'b1;
        k = 0;
        while (dm_req_valid !== 1'b1 && k < 20) begin @(negedge clk); #1; k++; end
        chk("rstfill_req_seen", k < 20, 1'b1);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; is_input_valid = 1'b0; mem_read = 1'b0;
        #1;
        chk("rstfill_is_ready", is_ready, 1'b1);
        chk("rstfill_req_valid", dm_req_valid, 1'b0);
        chk("rstfill_miss_count", miss_count, 32'h0);
        repeat (10) @(negedge clk);
        #1;
        chk("rstfill_still_idle", is_ready, 1'b1);
        resp_lat = 3;
        @(negedge clk);
        access(32'h100, 1'b0, 32'h0, fh, rd, cyc);
        chk("rstfill_reload_miss", fh, 1'b0);
        chk("rstfill_reload_dout", rd, 32'h1);
        chk("rstfill_miss_after", miss_count, 32'd1);
        chk("rstfill_hit_after", hit_count, 32'd1);

        // Saturation of the hit counter.
        force dut.hit_count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.hit_count_q;
        access(32'h104, 1'b0, 32'h0, fh, rd, cyc);
        chk("sat_first_hit", fh, 1'b1);
        chk("sat_dout", rd, 32'hDEAD);
        chk("sat_hit_count", hit_count, 32'hFFFF_FFFF);
        chk("sat_miss_count", miss_count, 32'd1);

        // Randomized accesses against the behavioural model.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin rv[i] = 1'b0; rdty[i] = 1'b0; rt[i] = '0; rdat[i] = '0; end
        mh = 0; mm = 0;
        resp_lat = 0; rand_ready = 1'b1;
        for (int n = 0; n < 80; n++) begin
            a  = 32'h0001_0000 | (32'($urandom_range(0, 3)) << 8) |
                 (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2);
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            s  = a[7:4]; t = a[31:8]; wi = int'(a[3:2]);
            la = a & 32'hFFFF_FFF0;
            eh = rv[s] && (rt[s] == t);
            exp_q.delete();
            if (!eh) begin
                mm++;
                if (rv[s] && rdty[s]) begin
                    exp_q.push_back('{1'b1, {rt[s], s, 4'h0}, rdat[s]});
                    ref_mem[{rt[s], s, 4'h0}] = rdat[s];
                end
                exp_q.push_back('{1'b0, la, 128'h0});
                rdat[s] = ref_line(la); rv[s] = 1'b1; rdty[s] = 1'b0; rt[s] = t;
            end
            mh++;
            erd = rdat[s][wi*32 +: 32];
            if (wr) begin rdat[s][wi*32 +: 32] = wd; rdty[s] = 1'b1; end
            req_log.delete();
            access(a, wr, wd, fh, rd, cyc);
            chk($sformatf("rnd%0d_hit", n), fh, eh);
            if (!wr) chk($sformatf("rnd%0d_dout", n), rd, erd);
            chk($sformatf("rnd%0d_nreq", n), req_log.size(), exp_q.size());
            if (req_log.size() == exp_q.size()) begin
                for (int j = 0; j < exp_q.size(); j++) begin
                    chk($sformatf("rnd%0d_req%0d_write", n, j), req_log[j].wr, exp_q[j].wr);
                    chk($sformatf("rnd%0d_req%0d_addr", n, j), req_log[j].a, exp_q[j].a);
                    if (exp_q[j].wr) chk($sformatf("rnd%0d_req%0d_data", n, j), req_log[j].d, exp_q[j].d);
                end
            end
        end
        rand_ready = 1'b0; dm_ready = 1'b1;
        #1;
        chk("rnd_hit_count", hit_count, 32'(mh));
        chk("rnd_miss_count", miss_count, 32'(mm));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache sitting between the pipeline's MEM stage and the line-granular data memory. It is the responder end of the MEM-stage request interface: the pipeline holds a request (`is_input_valid`, `addr`, `mem_read`/`mem_write`, `din`) stable and stalls until `is_ready && is_output_valid && is_hit`. Misses are resolved through a request/response handshake to the backing memory.

## Interface
- `LINE_WORDS`, default 4: 32-bit words per line. Power of two.
- `NUM_SETS`, default 16: number of lines. Power of two.
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `is_input_valid` in 1: request present. Held stable until completion.
- `addr` in 32: byte address, word-aligned. `addr[1:0]` is ignored.
- `mem_read` in 1: load request.
- `mem_write` in 1: store request. `mem_read` and `mem_write` are never both 1.
- `din` in 32: store data.
- `is_ready` out 1: cache is in IDLE. Reset value 1.
- `is_output_valid` out 1: the lookup result this cycle is valid. Reset value 0.
- `is_hit` out 1: the request hits this cycle. Reset value 0.
- `dout` out 32: load data, valid when the hit signals are high. Reset value 0.
- `dm_req_valid` out 1: memory request, one-cycle pulse. Reset value 0.
- `dm_req_write` out 1: 1 = line write-back, 0 = line fill. Reset value 0.
- `dm_req_addr` out 32: line-aligned byte address. Reset value 0.
- `dm_req_data` out 32*LINE_WORDS: victim line. Word 0 is in the LSBs. Reset value 0.
- `dm_ready` in 1: memory can accept a request.
- `dm_resp_valid` in 1: one-cycle pulse. Either fill data is valid, or a write-back is complete.
- `dm_resp_data` in 32*LINE_WORDS: fill data.
- `hit_count`, `miss_count` out 32 each: saturating performance counters. Reset value 0.

## Operation
- **Address split:**
  - `offset = addr[log2(LINE_WORDS)+1:2]`
  - `index = next log2(NUM_SETS) bits`
  - `tag = remaining upper bits`
- **Per-line state:** valid bit, dirty bit, tag, data. Reset clears every valid and dirty bit; data and tags are don't-care.
- **IDLE:**
  - `is_ready=1`.
  - On `is_input_valid` with valid && tag match: `is_hit=1` and `is_output_valid=1` combinationally in the same cycle.
  - Load hit: `dout` = addressed word.
  - Store hit: the word is written and dirty is set at the next edge.
  - `hit_count` increments once per hit.
  - Miss: `is_hit=0`, `miss_count` increments, and the FSM moves to WB_REQ if the victim is valid && dirty, otherwise to FILL_REQ.
- **WB_REQ:**
  - Wait for `dm_ready`, then pulse `dm_req_valid` with `dm_req_write=1`.
  - `dm_req_addr = {victim tag, index, 0}`; `dm_req_data` = victim line.
  - Go to WB_WAIT.
- **WB_WAIT:** on `dm_resp_valid`, clear dirty and go to FILL_REQ.
- **FILL_REQ:** wait for `dm_ready`, pulse `dm_req_valid` with `dm_req_write=0` and `dm_req_addr = {tag, index, 0}`, then go to FILL_WAIT.
- **FILL_WAIT:**
  - On `dm_resp_valid`, write the line, set valid, clear dirty, store the tag.
  - Return to IDLE. The held request then hits on the next cycle; the store merges at that point.
- Outside IDLE: `is_ready=0`, `is_hit=0`, `is_output_valid=0`, `dout=0`.
- `is_input_valid=0` in IDLE: `is_hit=0`, `is_output_valid=0`, no array change.
- Counters saturate at 32'hFFFF_FFFF.
- A miss is counted once per miss episode. The re-lookup after a fill counts as a hit.

## Timing
- Hit latency: 0 cycles. The result is combinational, and the pipeline advances at the same edge.
- Clean miss: 1 cycle (IDLE→FILL_REQ) + request cycle + memory latency L + 1 re-lookup cycle.
- Dirty miss: adds the request cycle and memory latency of the write-back.
- Memory-side requests are issued only when `dm_ready=1`. `dm_req_*` are registered and valid only while `dm_req_valid=1`.
- `dm_resp_valid` outside WB_WAIT/FILL_WAIT is ignored.
- `reset` asserted in any state: next edge returns to IDLE, invalidates all lines, zeroes counters, and deasserts `dm_req_valid`. An in-flight memory response is discarded.
- Index wrap: consecutive lines map modulo NUM_SETS. Addresses differing only in tag conflict.

## Structure
- Shared package `dcache_pkg`:
  - state enum {IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT}
  - localparams for field widths, derived from LINE_WORDS/NUM_SETS
  - line-address helper function
- One sub-module, `dcache_array`:
  - valid/dirty/tag/data storage
  - asynchronous read port
  - synchronous write port: whole-line write with tag and flags, or single-word write that also sets dirty
  - bulk invalidate on `reset`
- `dcache_ctrl` holds the FSM, the counters and the output muxing.

## Test plan
- Reset, then load 0x100 → FILL request at addr 0x100; response returns words {1,2,3,4}; next cycle `is_hit=1`, `dout=1`; `miss_count=1`, `hit_count=1`.
- Store 0x104 ← 0xDEAD after the fill → same-cycle hit; a later load of 0x104 returns 0xDEAD with 0 stall cycles.
- Load 0x500 (same index as 0x100, dirty) → write-back of line 0x100 with word 1 = 0xDEAD first, then the fill of 0x500.
- Hold `dm_ready=0` for 5 cycles during FILL_REQ → no `dm_req_valid` until `dm_ready=1`; `is_ready` stays 0 throughout.
- Assert `reset` during FILL_WAIT, then deliver `dm_resp_valid` → response ignored; a load of 0x100 misses again.
- Force the counter to 32'hFFFF_FFFF, then hit → it stays at 32'hFFFF_FFFF.
